// File: rtl/ula_display.sv
// Converts an 8-bit ALU result to BCD with a sequential double dabble and
// shows it on a multiplexed four-digit, active-low seven-segment display.
module ula_display #(
    parameter int DIV_VARREDURA = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] entrada,
    input  logic       com_sinal,
    input  logic       carregar,
    output logic       ocupado,
    output logic       pronto,
    output logic [6:0] segmentos,
    output logic [3:0] anodos
);

    localparam int CW = (DIV_VARREDURA > 1) ? $clog2(DIV_VARREDURA) : 1;

    localparam logic [6:0] SEG_BRANCO = 7'h7F;
    localparam logic [6:0] SEG_MENOS  = 7'h3F;

    typedef enum logic {OCIOSO, CONVERTE} estado_t;

    estado_t     estado;
    logic [2:0]  iter;
    logic [7:0]  desloc;
    logic [11:0] bcd;
    logic        neg_conv;

    logic        disp_neg;
    logic [3:0]  disp_c;
    logic [3:0]  disp_d;
    logic [3:0]  disp_u;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;

    logic [11:0] bcd_aj;
    logic [11:0] bcd_prox;
    logic        wrap;
    logic [1:0]  idx_prox;
    logic [6:0]  seg_prox;

    function automatic logic [3:0] ajusta(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Two's-complement magnitude; 8'h80 negated stays 8'h80, i.e. 128 unsigned.
    function automatic logic [7:0] magnitude(input logic [7:0] v, input logic neg);
        return neg ? (~v + 8'd1) : v;
    endfunction

    function automatic logic [6:0] sete_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BRANCO;
        endcase
    endfunction

    function automatic logic [3:0] anodo_de(input logic [1:0] i);
        return ~(4'b0001 << i);
    endfunction

    always_comb begin
        bcd_aj   = {ajusta(bcd[11:8]), ajusta(bcd[7:4]), ajusta(bcd[3:0])};
        bcd_prox = {bcd_aj[10:0], desloc[7]};
    end

    // Conversion FSM: E0 captures, E1..E8 run the eight iterations, E8 commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado   <= OCIOSO;
            ocupado  <= 1'b0;
            pronto   <= 1'b0;
            iter     <= 3'd0;
            desloc   <= 8'd0;
            bcd      <= 12'd0;
            neg_conv <= 1'b0;
            disp_neg <= 1'b0;
            disp_c   <= 4'd0;
            disp_d   <= 4'd0;
            disp_u   <= 4'd0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (carregar) begin
                        neg_conv <= com_sinal & entrada[7];
                        desloc   <= magnitude(entrada, com_sinal & entrada[7]);
                        bcd      <= 12'd0;
                        iter     <= 3'd0;
                        ocupado  <= 1'b1;
                        estado   <= CONVERTE;
                    end
                end
                CONVERTE: begin
                    bcd    <= bcd_prox;
                    desloc <= {desloc[6:0], 1'b0};
                    iter   <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        disp_neg <= neg_conv;
                        disp_c   <= bcd_prox[11:8];
                        disp_d   <= bcd_prox[7:4];
                        disp_u   <= bcd_prox[3:0];
                        ocupado  <= 1'b0;
                        pronto   <= 1'b1;
                        estado   <= OCIOSO;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    // Outputs are computed from the next digit index so anodes and segments
    // change together on the same edge.
    always_comb begin
        wrap     = (cnt == CW'(DIV_VARREDURA - 1));
        idx_prox = wrap ? idx + 2'd1 : idx;
        seg_prox = SEG_BRANCO;
        case (idx_prox)
            2'd0: seg_prox = sete_seg(disp_u);
            2'd1: seg_prox = (disp_c == 4'd0 && disp_d == 4'd0) ? SEG_BRANCO : sete_seg(disp_d);
            2'd2: seg_prox = (disp_c == 4'd0) ? SEG_BRANCO : sete_seg(disp_c);
            2'd3: seg_prox = disp_neg ? SEG_MENOS : SEG_BRANCO;
            default: seg_prox = SEG_BRANCO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            idx       <= 2'd0;
            anodos    <= 4'b1110;
            segmentos <= 7'h40;
        end else begin
            cnt       <= wrap ? '0 : cnt + CW'(1);
            idx       <= idx_prox;
            anodos    <= anodo_de(idx_prox);
            segmentos <= seg_prox;
        end
    end

endmodule

// File: tb/tb_ula_display.sv
// Scoreboard bench for ula_display: expected digit codes are queued on each
// load and compared against the scanned display after pronto.
module tb_ula_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] entrada;
    logic       com_sinal;
    logic       carregar;
    logic       ocupado;
    logic       pronto;
    logic [6:0] segmentos;
    logic [3:0] anodos;

    int n_tests = 0;
    int n_fail  = 0;

    logic [27:0] exp_q[$];
    logic [27:0] last_disp;

    ula_display #(.DIV_VARREDURA(DIV)) dut (
        .clk(clk),
        .reset(reset),
        .entrada(entrada),
        .com_sinal(com_sinal),
        .carregar(carregar),
        .ocupado(ocupado),
        .pronto(pronto),
        .segmentos(segmentos),
        .anodos(anodos)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected {digit3,digit2,digit1,digit0} from decimal arithmetic.
    function automatic logic [27:0] modelo(input logic [7:0] e, input logic s);
        logic neg;
        int mag, h, t, u;
        neg = s & e[7];
        mag = neg ? 256 - int'(e) : int'(e);
        h = mag / 100;
        t = (mag / 10) % 10;
        u = mag % 10;
        return {neg ? 7'h3F : 7'h7F,
                (h != 0) ? enc(h) : 7'h7F,
                (h != 0 || t != 0) ? enc(t) : 7'h7F,
                enc(u)};
    endfunction

    task automatic captura(output logic [27:0] vis, output logic ok);
        vis = 'x;
        ok  = 1'b1;
        repeat (4 * DIV) begin
            @(negedge clk);
            case (anodos)
                4'b1110: vis[6:0]   = segmentos;
                4'b1101: vis[13:7]  = segmentos;
                4'b1011: vis[20:14] = segmentos;
                4'b0111: vis[27:21] = segmentos;
                default: ok = 1'b0;
            endcase
        end
    endtask

    task automatic confere_display(input string nome, input logic [27:0] exp);
        logic [27:0] vis;
        logic ok;
        captura(vis, ok);
        n_tests++;
        if (vis !== exp || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s display: got %h (anodes ok=%b) expected %h", nome, vis, ok, exp);
        end
        last_disp = exp;
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int di;
        reset = 1'b1; carregar = 1'b0; entrada = 8'h00; com_sinal = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({anodos, segmentos} !== {4'b1110, 7'h40}) begin
            n_fail++;
            $display("FAIL reset outputs: got %b/%h expected 1110/40", anodos, segmentos);
        end
        n_tests++;
        if ({ocupado, pronto} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset flags: got ocupado=%b pronto=%b expected 0/0", ocupado, pronto);
        end
        reset = 1'b0;
        for (int k = 1; k <= 8 * DIV; k++) begin
            @(negedge clk);
            di      = (k / DIV) % 4;
            exp_an  = ~(4'b0001 << di);
            exp_seg = (di == 0) ? 7'h40 : 7'h7F;
            n_tests++;
            if ({anodos, segmentos} !== {exp_an, exp_seg}) begin
                n_fail++;
                $display("FAIL scan cycle %0d: got %b/%h expected %b/%h", k, anodos, segmentos, exp_an, exp_seg);
            end
        end
        last_disp = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    endtask

    task automatic test_convert(input string nome, input logic [7:0] e, input logic s);
        int n;
        logic [27:0] exp;
        exp_q.push_back(modelo(e, s));
        @(negedge clk);
        entrada = e; com_sinal = s; carregar = 1'b1;
        @(negedge clk);
        carregar = 1'b0;
        n = 0;
        while (ocupado === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        n_tests++;
        if (n != 8) begin
            n_fail++;
            $display("FAIL %s busy length: got %0d cycles expected 8", nome, n);
        end
        n_tests++;
        if (pronto !== 1'b1) begin
            n_fail++;
            $display("FAIL %s pronto at E8: got %b expected 1", nome, pronto);
        end
        exp = 'x;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        @(negedge clk);
        n_tests++;
        if (pronto !== 1'b0) begin
            n_fail++;
            $display("FAIL %s pronto width: got %b after E9 expected 0", nome, pronto);
        end
        confere_display(nome, exp);
    endtask

    task automatic test_back_to_back();
        int n_oc, n_pr;
        logic [6:0] exp_seg;
        logic [27:0] exp;
        exp_q.push_back(modelo(8'h64, 1'b0));
        @(negedge clk);
        entrada = 8'h64; com_sinal = 1'b0; carregar = 1'b1;
        n_oc = 0; n_pr = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ocupado === 1'b1) begin
                n_oc++;
                case (anodos)
                    4'b1110: exp_seg = last_disp[6:0];
                    4'b1101: exp_seg = last_disp[13:7];
                    4'b1011: exp_seg = last_disp[20:14];
                    default: exp_seg = last_disp[27:21];
                endcase
                n_tests++;
                if (segmentos !== exp_seg) begin
                    n_fail++;
                    $display("FAIL hold during conversion: anodos %b got %h expected %h", anodos, segmentos, exp_seg);
                end
            end
            if (pronto === 1'b1) n_pr++;
            carregar = (k == 3);
            if (k == 3) entrada = 8'h05;
        end
        n_tests++;
        if (n_oc != 8 || n_pr != 1) begin
            n_fail++;
            $display("FAIL retrigger ignored: got busy=%0d pronto=%0d expected 8/1", n_oc, n_pr);
        end
        exp = 'x;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        confere_display("back_to_back", exp);
    endtask

    task automatic test_reset_abort();
        int n_bad;
        @(negedge clk);
        entrada = 8'hFF; com_sinal = 1'b0; carregar = 1'b1;
        @(negedge clk);
        carregar = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({ocupado, pronto, anodos, segmentos} !== {2'b00, 4'b1110, 7'h40}) begin
            n_fail++;
            $display("FAIL abort reset: got ocupado=%b pronto=%b %b/%h expected 0/0 1110/40",
                     ocupado, pronto, anodos, segmentos);
        end
        reset = 1'b0;
        n_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (ocupado !== 1'b0 || pronto !== 1'b0) n_bad++;
        end
        n_tests++;
        if (n_bad != 0) begin
            n_fail++;
            $display("FAIL abort flags: got %0d busy/pronto cycles expected 0", n_bad);
        end
        confere_display("abort", {7'h7F, 7'h7F, 7'h7F, 7'h40});
    endtask

    initial begin
        reset = 1'b1; carregar = 1'b0; entrada = 8'h00; com_sinal = 1'b0;
        test_reset();
        test_convert("u30",    8'h1E, 1'b0);
        test_convert("s_m1",   8'hFF, 1'b1);
        test_convert("u255",   8'hFF, 1'b0);
        test_convert("s_m128", 8'h80, 1'b1);
        test_convert("u225",   8'hE1, 1'b0);
        test_convert("s_m100", 8'h9C, 1'b1);
        test_convert("s_p7",   8'h07, 1'b1);
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
